// File: rtl/mult_accum_ctrl.sv
// mult_accum_ctrl
//   Feeds an external unsigned pipelined multiplier (MULT_LAT stages, no input
//   or output register) with operand pairs from a framed stream. It also sums
//   the returned products over each frame. When a frame completes, it reports
//   the saturating frame sum, the beat count and an overflow flag as a
//   one-cycle pulse.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand pair handshake (accept = in_valid & in_ready)
//   in_a, in_b, in_last   operand pair and end-of-frame marker
//   mult_ce               multiplier clock enable (always 1 out of reset)
//   mult_a, mult_b        registered operands to the multiplier
//   mult_p                multiplier product, valid MULT_LAT clocks after sampling
//   sum_valid             one-cycle pulse qualifying sum_out/cnt_out/ovf
//   sum_out, cnt_out, ovf frame sum, beat count, saturation flag (held)
module mult_accum_ctrl #(
  parameter int OP_W     = 16,
  parameter int MULT_LAT = 3,
  parameter int ACC_W    = 48,
  parameter int CNT_W    = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_a,
  input  logic [OP_W-1:0]    in_b,
  input  logic               in_last,
  output logic               mult_ce,
  output logic [OP_W-1:0]    mult_a,
  output logic [OP_W-1:0]    mult_b,
  input  logic [2*OP_W-1:0]  mult_p,
  output logic               sum_valid,
  output logic [ACC_W-1:0]   sum_out,
  output logic [CNT_W-1:0]   cnt_out,
  output logic               ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [MULT_LAT:0]  r_vld;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               w_accept;
  logic               w_first;
  logic               w_add;
  logic [ACC_W:0]     w_acc_sum;
  logic [CNT_W:0]     w_cnt_inc;

  // Saturating accumulate: MSB of the result is the overflow flag.
  function automatic logic [ACC_W:0] acc_add_sat(input logic [ACC_W-1:0] acc,
                                                 input logic [2*OP_W-1:0] p);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + (ACC_W+1)'(p);
    if (s[ACC_W]) s = {1'b1, {ACC_W{1'b1}}};
    return s;
  endfunction

  // Saturating increment: MSB of the result is the overflow flag.
  function automatic logic [CNT_W:0] cnt_inc_sat(input logic [CNT_W-1:0] cnt);
    logic [CNT_W:0] s;
    if (&cnt) s = {1'b1, cnt};
    else      s = {1'b0, cnt + CNT_W'(1)};
    return s;
  endfunction

  assign mult_ce   = 1'b1;
  assign in_ready  = (r_state == S_IDLE) || (r_state == S_ACCUM);
  assign w_accept  = in_valid & in_ready;
  assign w_first   = w_accept && (r_state == S_IDLE);
  // The oldest valid bit lines up with the product on mult_p this cycle.
  assign w_add     = r_vld[MULT_LAT];
  assign w_acc_sum = acc_add_sat(r_acc, mult_p);
  assign w_cnt_inc = cnt_inc_sat(r_cnt);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = in_last ? S_DRAIN : S_ACCUM;
      S_ACCUM: if (w_accept && in_last) w_state_nxt = S_DRAIN;
      // Only the oldest bit may remain set: its product is added at this
      // edge, so the accumulator is final for the DONE cycle.
      S_DRAIN: if (r_vld[MULT_LAT-1:0] == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_vld   <= '0;
      mult_a  <= '0;
      mult_b  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vld   <= {r_vld[MULT_LAT-1:0], w_accept};
      if (w_accept) begin
        mult_a <= in_a;
        mult_b <= in_b;
      end
    end
  end

  // Frame accumulation: the first beat restarts the frame (the product pipe
  // is empty then, so no add is lost).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_first) begin
      r_acc <= '0;
      r_cnt <= CNT_W'(1);
      r_ovf <= 1'b0;
    end else begin
      if (w_add)    r_acc <= w_acc_sum[ACC_W-1:0];
      if (w_accept) r_cnt <= w_cnt_inc[CNT_W-1:0];
      r_ovf <= r_ovf | (w_add & w_acc_sum[ACC_W]) | (w_accept & w_cnt_inc[CNT_W]);
    end
  end

  // Result stage: captured during DONE, held until the next frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_valid <= 1'b0;
      sum_out   <= '0;
      cnt_out   <= '0;
      ovf       <= 1'b0;
    end else begin
      sum_valid <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        sum_out <= r_acc;
        cnt_out <= r_cnt;
        ovf     <= r_ovf;
      end
    end
  end

endmodule

// File: tb/tb_mult_accum_ctrl.sv
module tb_mult_accum_ctrl;

  localparam longint unsigned MAX48 = 64'h0000_FFFF_FFFF_FFFF;
  localparam longint unsigned MAX33 = 64'h0000_0001_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_last = 1'b0;

  logic        rdy48, ce48, sv48, ovf48;
  logic [15:0] ma48, mb48;
  logic [31:0] mp48;
  logic [47:0] sum48;
  logic [19:0] cnt48;

  logic        rdy33, ce33, sv33, ovf33;
  logic [15:0] ma33, mb33;
  logic [31:0] mp33;
  logic [32:0] sum33;
  logic [19:0] cnt33;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_accum_ctrl #(.OP_W(16), .MULT_LAT(3), .ACC_W(48), .CNT_W(20)) dut48 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy48),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mult_ce(ce48),
    .mult_a(ma48), .mult_b(mb48), .mult_p(mp48), .sum_valid(sv48),
    .sum_out(sum48), .cnt_out(cnt48), .ovf(ovf48));

  mult_accum_ctrl #(.OP_W(16), .MULT_LAT(3), .ACC_W(33), .CNT_W(20)) dut33 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy33),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mult_ce(ce33),
    .mult_a(ma33), .mult_b(mb33), .mult_p(mp33), .sum_valid(sv33),
    .sum_out(sum33), .cnt_out(cnt33), .ovf(ovf33));

  // Behavioural 3-stage multipliers (not reset, like the real macro).
  logic [31:0] m48_s1, m48_s2, m48_s3, m33_s1, m33_s2, m33_s3;
  always @(posedge clk) begin
    if (ce48) begin
      m48_s1 <= 32'(ma48) * 32'(mb48);
      m48_s2 <= m48_s1;
      m48_s3 <= m48_s2;
    end
    if (ce33) begin
      m33_s1 <= 32'(ma33) * 32'(mb33);
      m33_s2 <= m33_s1;
      m33_s3 <= m33_s2;
    end
  end
  assign mp48 = m48_s3;
  assign mp33 = m33_s3;

  // Reference model: exact frame totals from the accepted beats.
  typedef struct {longint unsigned tot; int n; int edg;} exp_t;
  typedef struct {int cyc; logic [47:0] s48; logic [19:0] c48; logic o48;
                  logic sv33; logic [32:0] s33; logic [19:0] c33; logic o33;} obs_t;
  exp_t exp_q[$];
  obs_t obs_q[$];
  longint unsigned m_tot = 0;
  int m_n = 0;

  always @(negedge clk) begin : monitor
    longint unsigned nt;
    int nn;
    nt = m_tot;
    nn = m_n;
    if (!rst_n) begin
      nt = 0;
      nn = 0;
    end else if (in_valid && rdy48) begin
      nt = nt + longint'(in_a) * longint'(in_b);
      nn = nn + 1;
      if (in_last) begin
        exp_q.push_back('{nt, nn, cyc + 1});
        nt = 0;
        nn = 0;
      end
    end
    m_tot <= nt;
    m_n   <= nn;
    if (sv48 || sv33)
      obs_q.push_back('{cyc, sum48, cnt48, ovf48, sv33, sum33, cnt33, ovf33});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    int w = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    @(negedge clk);
    while (!rdy48 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("send_ready_timeout", rdy48, 1);
    @(posedge clk);
    #1;
  endtask

  // Idle cycles carry junk data and a stray in_last that must be ignored.
  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last = 1'b1;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_frame(input string tag, output obs_t o);
    exp_t e;
    int w = 0;
    o = '{0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0};
    while (obs_q.size() == 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ".sum_valid_seen"}, obs_q.size() != 0, 1);
    chk({tag, ".expected_frame"}, exp_q.size() != 0, 1);
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, ".latency"}, 64'(o.cyc - e.edg), 5);
      chk({tag, ".sum48"}, o.s48, (e.tot > MAX48) ? MAX48 : e.tot);
      chk({tag, ".cnt48"}, o.c48, e.n);
      chk({tag, ".ovf48"}, o.o48, e.tot > MAX48);
      chk({tag, ".sv33"}, o.sv33, 1);
      chk({tag, ".sum33"}, o.s33, (e.tot > MAX33) ? MAX33 : e.tot);
      chk({tag, ".cnt33"}, o.c33, e.n);
      chk({tag, ".ovf33"}, o.o33, e.tot > MAX33);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"}, rdy48, 1);
    chk({tag, ".sum_valid"}, sv48, 0);
    chk({tag, ".sum_out"}, sum48, 0);
    chk({tag, ".cnt_out"}, cnt48, 0);
    chk({tag, ".ovf"}, ovf48, 0);
    chk({tag, ".mult_ce"}, ce48, 1);
    chk({tag, ".mult_a"}, ma48, 0);
    chk({tag, ".sum33"}, sum33, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t o;
    int low;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("t1_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    chk("t1_ce_after_reset", ce48, 1);

    // Back-to-back frame with a full-scale product
    send(16'd3, 16'd5, 1'b0);
    send(16'd7, 16'd11, 1'b0);
    send(16'd65535, 16'd65535, 1'b0);
    send(16'd0, 16'd9, 1'b1);
    idle(1);
    check_frame("t2", o);
    chk("t2.sum_lit", o.s48, 64'd4294836317);
    chk("t2.cnt_lit", o.c48, 4);

    // Single beat from IDLE; in_ready low for the drain/done window
    idle(2);
    send(16'd100, 16'd200, 1'b1);
    in_valid = 1'b0;
    low = 0;
    @(negedge clk);
    while (!rdy48 && low < 20) begin
      low++;
      @(negedge clk);
    end
    chk("t3.ready_low_cycles", low, 5);
    check_frame("t3", o);
    chk("t3.sum_lit", o.s48, 64'd20000);

    // Bubbles, then a pair held through in_ready=0 accepted once
    idle(2);
    send(16'd2, 16'd2, 1'b0); idle(1);
    send(16'd2, 16'd2, 1'b0); idle(1);
    send(16'd2, 16'd2, 1'b0); idle(1);
    send(16'd2, 16'd2, 1'b1);
    send(16'd4, 16'd4, 1'b1);
    idle(1);
    check_frame("t4", o);
    chk("t4.sum_lit", o.s48, 64'd16);
    chk("t4.cnt_lit", o.c48, 4);
    check_frame("t4_held", o);
    chk("t4_held.cnt_lit", o.c48, 1);

    // Saturation in the 33-bit instance, then a clean frame clears ovf
    idle(2);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    idle(1);
    check_frame("t5", o);
    chk("t5.sum33_lit", o.s33, 64'd8589934591);
    chk("t5.ovf33_lit", o.o33, 1);
    idle(2);
    send(16'd1, 16'd1, 1'b1);
    idle(1);
    check_frame("t5b", o);
    chk("t5b.sum33_lit", o.s33, 1);
    chk("t5b.ovf33_lit", o.o33, 0);

    // Reset one clock after the second accept of a frame
    idle(2);
    send(16'd9, 16'd9, 1'b0);
    send(16'd8, 16'd8, 1'b0);
    idle(1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t6_midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(16'd4, 16'd4, 1'b1);
    idle(1);
    check_frame("t6", o);
    chk("t6.sum_lit", o.s48, 64'd16);
    chk("t6.cnt_lit", o.c48, 1);

    // Random frames with random gaps and frequent full-scale operands
    for (int f = 0; f < 10; f++) begin
      int len;
      len = $urandom_range(1, 6);
      idle($urandom_range(1, 3));
      for (int k = 0; k < len; k++) begin
        logic [15:0] a, b;
        a = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
        b = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
        send(a, b, k == len - 1);
        if (k != len - 1 && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
      idle(1);
      check_frame($sformatf("rand%0d", f), o);
    end

    // No spurious result pulses anywhere
    idle(12);
    chk("no_extra_sum_valid", obs_q.size(), 0);
    chk("no_pending_frames", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
